// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin arbiter and sequencer for a
// single-port synchronous memory (one ce/wr/rd strobe per transaction).
// Ports: clk, rst (sync, active high); per port reqN/weN/addrN/wdataN in,
//        ackN/rdataN out; busy out; ce/wr/rd/mem_addr/mem_wdata to the
//        memory, mem_rdata from it (valid the cycle after a read strobe).
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ce,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                port_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                last_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                any_req;
    logic                grant1;

    assign any_req = req0 | req1;
    // Port 1 wins when alone, or on a tie when port 0 was served last.
    assign grant1  = req1 & (~req0 | ~last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = WAIT;
            WAIT:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            last_q   <= 1'b1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                port_q  <= grant1;
                we_q    <= grant1 ? we1 : we0;
                addr_q  <= grant1 ? addr1 : addr0;
                wdata_q <= grant1 ? wdata1 : wdata0;
                last_q  <= grant1;
            end
            if (state_q == WAIT && !we_q) begin
                if (port_q) begin
                    rdata1_q <= mem_rdata;
                end else begin
                    rdata0_q <= mem_rdata;
                end
            end
        end
    end

    // Strobes and acks are masked by rst so a transaction caught by reset
    // never reaches the memory or the requester in that same cycle.
    always_comb begin
        ce   = (state_q == ACCESS) & ~rst;
        wr   = ce & we_q;
        rd   = ce & ~we_q;
        ack0 = (state_q == ACK) & ~port_q & ~rst;
        ack1 = (state_q == ACK) & port_q & ~rst;
        busy = (state_q != IDLE);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed + random bench for mem_port_arbiter with a
// memory model and a transaction-level reference model.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, busy, ce, wr, rd;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .ce(ce), .wr(wr), .rd(rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [7:0] mem [256];
    logic       mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            if (ce && wr) mem[mem_addr] <= mem_wdata;
            if (ce && rd) mem_rdata <= mem[mem_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    // reference model state
    logic [7:0] refmem [256];
    int         lg;
    logic [7:0] exp_rd0, exp_rd1;
    int         ack_cyc;

    always @(negedge clk) begin
        n_tests++;
        assert (!(wr && rd)) else begin
            n_fail++;
            $error("FAIL inv_wr_rd: wr=%0b rd=%0b required not both", wr, rd);
        end
        n_tests++;
        assert (ce || (!wr && !rd)) else begin
            n_fail++;
            $error("FAIL inv_ce: ce=%0b wr=%0b rd=%0b", ce, wr, rd);
        end
        n_tests++;
        assert (!(ack0 && ack1)) else begin
            n_fail++;
            $error("FAIL inv_ack: ack0=%0b ack1=%0b", ack0, ack1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transaction, entered at the negedge of an IDLE cycle.
    task automatic txn(input bit r0, input bit r1, input bit drop_early);
        int         w;
        logic       we_w;
        logic [7:0] a_w, d_w;
        req0 = r0;
        req1 = r1;
        w    = (r0 && r1) ? ((lg == 1) ? 0 : 1) : (r0 ? 0 : 1);
        we_w = w ? we1 : we0;
        a_w  = w ? addr1 : addr0;
        d_w  = w ? wdata1 : wdata0;
        step();
        check("ce_access", ce, 1);
        check("wr_access", wr, we_w);
        check("rd_access", rd, !we_w);
        check("mem_addr", mem_addr, a_w);
        check("mem_wdata", mem_wdata, d_w);
        check("busy_access", busy, 1);
        check("ack_access", {ack0, ack1}, 0);
        if (drop_early) begin
            if (w == 1) req1 = 0;
            else req0 = 0;
        end
        step();
        check("strobes_wait", {ce, wr, rd}, 0);
        check("busy_wait", busy, 1);
        check("ack_wait", {ack0, ack1}, 0);
        if (we_w) refmem[a_w] = d_w;
        else if (w == 1) exp_rd1 = refmem[a_w];
        else exp_rd0 = refmem[a_w];
        lg = w;
        step();
        check("ack0", ack0, (w == 0));
        check("ack1", ack1, (w == 1));
        check("rdata0", rdata0, exp_rd0);
        check("rdata1", rdata1, exp_rd1);
        check("busy_ack", busy, 1);
        check("ce_ack", ce, 0);
        ack_cyc = cyc;
        if (w == 1) req1 = 0;
        else req0 = 0;
        step();
        check("busy_idle", busy, 0);
        check("ack_idle", {ack0, ack1}, 0);
    endtask

    initial begin
        int prev;
        int r;
        rst     = 1;
        mem_clr = 1;
        req0    = 1;
        req1    = 1;
        we0     = 1;
        addr0   = 8'h12;
        wdata0  = 8'hA5;
        we1     = 0;
        addr1   = 8'h12;
        wdata1  = 8'h00;
        for (int i = 0; i < 256; i++) refmem[i] = 8'h00;
        lg      = 1;
        exp_rd0 = 8'h00;
        exp_rd1 = 8'h00;
        ack_cyc = 0;

        repeat (3) begin
            @(negedge clk);
            check("rst_ctl", {ce, wr, rd, ack0, ack1, busy}, 0);
            check("rst_addr", {mem_addr, mem_wdata}, 0);
            check("rst_rdata", {rdata0, rdata1}, 0);
        end
        rst     = 0;
        mem_clr = 0;

        // tie after reset goes to port 0: write 0x12 <= 0xA5
        txn(1, 1, 0);
        check("mem_12", mem[8'h12], 8'hA5);
        // port 1 reads it back
        txn(0, 1, 0);
        check("readback", rdata1, 8'hA5);
        check("rdata0_kept", rdata0, 8'h00);

        // fairness: both ports continuously requesting
        we0   = 0;
        addr0 = 8'h12;
        we1   = 1;
        addr1 = 8'h20;
        wdata1 = 8'h3C;
        prev  = 0;
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 0);
            check("fair_order", lg, i % 2);
            if (i > 0) check("ack_spacing", ack_cyc - prev, 4);
            prev = ack_cyc;
        end

        // request dropped right after grant still completes
        we0    = 1;
        addr0  = 8'h34;
        wdata0 = 8'h5A;
        txn(1, 0, 1);
        check("mem_34", mem[8'h34], 8'h5A);

        // random mix
        for (int i = 0; i < 12; i++) begin
            r      = $urandom_range(1, 3);
            we0    = 1'($urandom);
            we1    = 1'($urandom);
            addr0  = 8'($urandom_range(0, 15));
            addr1  = 8'($urandom_range(0, 15));
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            txn(r[0], r[1], 0);
        end

        // reset during the ACCESS cycle of a write
        we0    = 1;
        addr0  = 8'h80;
        wdata0 = 8'hEE;
        req0   = 1;
        req1   = 0;
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        check("abort_ce", ce, 0);
        check("abort_wr", wr, 0);
        req0 = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        check("abort_busy", busy, 0);
        check("abort_mem", mem[8'h80], refmem[8'h80]);
        check("abort_rdata", {rdata0, rdata1}, 0);
        check("abort_addr", mem_addr, 0);
        lg      = 1;
        exp_rd0 = 8'h00;
        exp_rd1 = 8'h00;
        repeat (4) begin
            step();
            check("abort_noack", {ack0, ack1}, 0);
        end
        we0   = 0;
        addr0 = 8'h12;
        we1   = 0;
        addr1 = 8'h34;
        txn(1, 1, 0);
        check("post_rst_winner", lg, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
